aidc_lite_code_packer: RTL and testbench
========================================

AIDC_LITE_CODE_PACKER -- requirements
Module: aidc_lite_code_packer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 The block SHALL have the following parameters:
- PREFIX_W: default 2; block-header prefix width in bits.
- PREFIX: default 2'b00; prefix value.
- DATA_SIZE: default 66; input code field width.
- SIZE_W: default 7; width of size_i.
- OUT_W: default 64; output word width.
- MAX_WORDS: default 8; maximum number of words per block.
REQ-003 The block SHALL have the following ports, listed as name, direction, width, meaning:
- clk  in  1  clock.
- rst  in  1  async active-high reset.
- valid_i  in  1  input beat valid.
- ready_o  out  1  input beat accepted when valid_i and ready_o are both high.
- sop_i  in  1  first beat of a block.
- eop_i  in  1  last beat of a block.
- data_i  in  DATA_SIZE  code bits, MSB-aligned.
- size_i  in  SIZE_W  number of valid code bits in data_i.
- valid_o  out  1  output word valid.
- ready_i  in  1  downstream accepts the output word.
- addr_o  out  $clog2(MAX_WORDS)  word index within the block.
- data_o  out  OUT_W  packed word.
- done_o  out  1  block complete (level).
- fail_o  out  1  block exceeded MAX_WORDS (level).

Function
REQ-004 The code bits of a beat SHALL be data_i[DATA_SIZE-1 -: size_i]; bits below the code field SHALL be masked to 0; a size_i greater than DATA_SIZE SHALL be clamped to DATA_SIZE; a size_i of 0 SHALL be accepted and add no bits.
REQ-005 Packing SHALL be MSB-first: each block starts with PREFIX in the top bits of word 0, followed by the code bits of each beat in arrival order.
REQ-006 The accumulator SHALL be OUT_W-1+DATA_SIZE bits wide, and its bit count buf_bits SHALL be tracked exactly.
REQ-007 The state machine SHALL have two states:
- FILL: accept beats and emit full words.
- DRAIN: entered on an accepted eop beat; emit all remaining full words, then emit one zero-padded partial word if buf_bits>0, then return to FILL.
REQ-008 ready_o SHALL be 1 only when state==FILL, buf_bits<OUT_W, and the output slot is empty or ready_i is high.
REQ-009 A word SHALL appear on valid_o in the cycle after the beat that completes it.
REQ-010 Once valid_o is raised, valid_o, data_o and addr_o SHALL be held stable until a cycle in which ready_i is high.
REQ-011 At most one word SHALL be emitted per cycle; buf_bits SHALL decrease by OUT_W per emitted full word.
REQ-012 addr_o SHALL increment per emitted word and reset to 0 at each block start.
REQ-013 Words with index >= MAX_WORDS SHALL be discarded rather than emitted, and fail_o SHALL be set to 1.
REQ-014 An accepted sop beat SHALL clear done_o and fail_o.
REQ-015 done_o SHALL be set in the cycle after the handshake of the last emitted word of a block, or after an eop beat that leaves nothing to emit.
REQ-016 At block end, the accumulator SHALL be reloaded with PREFIX at its MSBs and buf_bits set to PREFIX_W.
REQ-017 A sop accepted while a block is open SHALL discard the buffered bits (no emit), reload PREFIX, and start a new block with that beat.
REQ-018 A beat carrying both sop and eop SHALL form a complete block.

Reset
REQ-019 While rst is asserted, the block SHALL hold: valid_o=0, data_o=0, addr_o=0, done_o=1, fail_o=0, state=FILL, accumulator=PREFIX at its MSBs with all other bits 0, buf_bits=PREFIX_W.
REQ-020 ready_o SHALL be 1 after rst is released.
REQ-021 Reset asserted mid-block or mid-DRAIN SHALL abort the block without emitting further words.

Configuration
REQ-022 When AIDC_LITE_PACKER_STATS_EN is defined, the block SHALL add output blk_bits_o [15:0], loaded at each block end with the total block size in bits (prefix included, saturating at 16'hFFFF), with reset value 0.
REQ-023 When AIDC_LITE_PACKER_STATS_EN is not defined, the blk_bits_o port and its logic SHALL be absent.

Structure
REQ-024 The state enum and the PREFIX_W/OUT_W default constants SHALL reside in the shared package aidc_lite_pkg.
REQ-025 The masking and shift-or alignment SHALL be a combinational sub-module aidc_lite_bit_aligner; all sequential state SHALL stay in the top module.

Verification
REQ-026 Reset check: assert rst, then release -> valid_o=0, ready_o=1, done_o=1, fail_o=0, addr_o=0.
REQ-027 Basic block: beats (sop,size 6), (size 34), (eop,size 34) with ready_i=1 -> two words, addr 0 (64 bits with top 2 bits 00) and addr 1 (12 code bits then 52 zeros); done_o=1 after the addr 1 handshake.
REQ-028 Backpressure: ready_i=0 for 5 cycles while valid_o=1 -> data_o/addr_o stable, ready_o=0, no beat lost.
REQ-029 Overflow: 9 beats of size 66 (2+594=596 bits) -> words addr 0..7 emitted, remaining bits dropped, fail_o=1, done_o=1.
REQ-030 Mid-block sop: 2 beats of size 34 without eop, then a sop beat -> no word emitted for the discarded bits; next word starts with PREFIX at addr 0.
REQ-031 Reset during DRAIN: assert rst while valid_o=1 -> valid_o=0 immediately; next block starts at addr 0 with PREFIX.

Source files
------------

// File: rtl/aidc_lite_pkg.sv
// Shared types and default constants for the AIDC-lite code packer.
package aidc_lite_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam int DEF_PREFIX_W = 2;
  localparam int DEF_OUT_W    = 64;

endpackage

// File: rtl/aidc_lite_bit_aligner.sv
// Combinational aligner: masks the MSB-aligned code field of a beat and ORs it
// into the accumulator directly below the bits already buffered.
module aidc_lite_bit_aligner
  import aidc_lite_pkg::*;
#(
  parameter int DATA_SIZE = 66,
  parameter int SIZE_W    = 7,
  parameter int ACC_W     = 129,
  parameter int BB_W      = 8
) (
  input  logic [ACC_W-1:0]     acc_in,
  input  logic [BB_W-1:0]      bits_in,
  input  logic [DATA_SIZE-1:0] data,
  input  logic [SIZE_W-1:0]    size,
  output logic [ACC_W-1:0]     acc_out,
  output logic [BB_W-1:0]      bits_out
);

  localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(DATA_SIZE);

  logic [SIZE_W-1:0]    size_c;
  logic [DATA_SIZE-1:0] mask;
  logic [DATA_SIZE-1:0] code;
  logic [ACC_W-1:0]     code_ext;

  assign size_c   = (size > MAX_SIZE) ? MAX_SIZE : size;
  // Keep only the top size_c bits; a full-width shift yields an all-ones mask.
  assign mask     = ~({DATA_SIZE{1'b1}} >> size_c);
  assign code     = data & mask;
  assign code_ext = {code, {(ACC_W-DATA_SIZE){1'b0}}};
  assign acc_out  = acc_in | (code_ext >> bits_in);
  assign bits_out = bits_in + BB_W'(size_c);

endmodule

// File: rtl/aidc_lite_code_packer.sv
// Packs variable-length MSB-aligned codes into OUT_W-bit words behind a prefix.
// Optional block-size statistics output enabled by AIDC_LITE_PACKER_STATS_EN.
module aidc_lite_code_packer
  import aidc_lite_pkg::*;
#(
  parameter int                  PREFIX_W  = DEF_PREFIX_W,
  parameter logic [PREFIX_W-1:0] PREFIX    = '0,
  parameter int                  DATA_SIZE = 66,
  parameter int                  SIZE_W    = 7,
  parameter int                  OUT_W     = DEF_OUT_W,
  parameter int                  MAX_WORDS = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic                         sop_i,
  input  logic                         eop_i,
  input  logic [DATA_SIZE-1:0]         data_i,
  input  logic [SIZE_W-1:0]            size_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(MAX_WORDS)-1:0] addr_o,
  output logic [OUT_W-1:0]             data_o,
  output logic                         done_o,
  output logic                         fail_o
`ifdef AIDC_LITE_PACKER_STATS_EN
  ,
  output logic [15:0]                  blk_bits_o
`endif
);

  localparam int ACC_W = OUT_W - 1 + DATA_SIZE;
  localparam int BB_W  = $clog2(ACC_W + 1);
  localparam int AW    = $clog2(MAX_WORDS);
  localparam int CW    = $clog2(MAX_WORDS + 1);

  localparam logic [ACC_W-1:0] PREFIX_ACC  = {PREFIX, {(ACC_W-PREFIX_W){1'b0}}};
  localparam logic [BB_W-1:0]  PREFIX_BITS = BB_W'(PREFIX_W);
  localparam logic [BB_W-1:0]  OUT_BITS    = BB_W'(OUT_W);
  localparam logic [CW-1:0]    WORD_LIMIT  = CW'(MAX_WORDS);

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [BB_W-1:0]  bits_reg, bits_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic [OUT_W-1:0] out_data_reg, out_data_next;
  logic [AW-1:0]    out_addr_reg, out_addr_next;
  logic             done_reg, done_next;
  logic             fail_reg, fail_next;
  logic             pending_reg, pending_next;

  logic             accept, start, slot_open, overflow, full, draining;
  logic             emit, finish;
  logic [ACC_W-1:0] base_acc, aligned_acc, cur_acc;
  logic [BB_W-1:0]  base_bits, aligned_bits, cur_bits;
  logic [CW-1:0]    cnt_base;

  assign slot_open = !out_valid_reg || ready_i;
  assign ready_o   = (state_reg == ST_FILL) && (bits_reg < OUT_BITS) && slot_open;
  assign accept    = valid_i && ready_o;
  assign start     = accept && sop_i;

  // A sop beat lands on a freshly reloaded prefix, dropping any open block.
  assign base_acc  = start ? PREFIX_ACC : acc_reg;
  assign base_bits = start ? PREFIX_BITS : bits_reg;

  aidc_lite_bit_aligner #(
    .DATA_SIZE (DATA_SIZE),
    .SIZE_W    (SIZE_W),
    .ACC_W     (ACC_W),
    .BB_W      (BB_W)
  ) u_aligner (
    .acc_in   (base_acc),
    .bits_in  (base_bits),
    .data     (data_i),
    .size     (size_i),
    .acc_out  (aligned_acc),
    .bits_out (aligned_bits)
  );

  assign cur_acc  = accept ? aligned_acc : acc_reg;
  assign cur_bits = accept ? aligned_bits : bits_reg;
  assign cnt_base = start ? '0 : cnt_reg;
  assign overflow = cnt_base >= WORD_LIMIT;
  assign full     = cur_bits >= OUT_BITS;
  assign draining = state_reg == ST_DRAIN;

  // Words past MAX_WORDS are dropped, so they never wait for the output slot.
  assign emit   = (overflow || slot_open) && (full || (draining && cur_bits != '0));
  assign finish = draining && !full && (cur_bits == '0 || overflow || slot_open);

  always_comb begin
    state_next     = state_reg;
    acc_next       = cur_acc;
    bits_next      = cur_bits;
    cnt_next       = cnt_base;
    out_valid_next = out_valid_reg && !ready_i;
    out_data_next  = out_data_reg;
    out_addr_next  = out_addr_reg;
    fail_next      = (start ? 1'b0 : fail_reg) | (emit && overflow);
    done_next      = done_reg;
    pending_next   = pending_reg;

    if (accept && eop_i) begin
      state_next = ST_DRAIN;
    end else if (finish) begin
      state_next = ST_FILL;
    end

    if (finish) begin
      acc_next  = PREFIX_ACC;
      bits_next = PREFIX_BITS;
      cnt_next  = '0;
    end else if (emit) begin
      acc_next  = cur_acc << OUT_W;
      bits_next = cur_bits - OUT_BITS;
      if (!overflow) begin
        cnt_next = cnt_base + CW'(1);
      end
    end

    if (emit && !overflow) begin
      out_valid_next = 1'b1;
      out_data_next  = cur_acc[ACC_W-1 -: OUT_W];
      out_addr_next  = cnt_base[AW-1:0];
    end

    // done waits for the handshake of the block's last word still in the slot.
    if (start) begin
      done_next    = 1'b0;
      pending_next = 1'b0;
    end else if (finish) begin
      if (out_valid_next) begin
        pending_next = 1'b1;
      end else begin
        done_next = 1'b1;
      end
    end else if (pending_reg && out_valid_reg && ready_i) begin
      pending_next = 1'b0;
      done_next    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_FILL;
      acc_reg       <= PREFIX_ACC;
      bits_reg      <= PREFIX_BITS;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_addr_reg  <= '0;
      done_reg      <= 1'b1;
      fail_reg      <= 1'b0;
      pending_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      bits_reg      <= bits_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_addr_reg  <= out_addr_next;
      done_reg      <= done_next;
      fail_reg      <= fail_next;
      pending_reg   <= pending_next;
    end
  end

  assign valid_o = out_valid_reg;
  assign data_o  = out_data_reg;
  assign addr_o  = out_addr_reg;
  assign done_o  = done_reg;
  assign fail_o  = fail_reg;

`ifdef AIDC_LITE_PACKER_STATS_EN
  logic [15:0] total_reg, total_next;
  logic [15:0] blk_bits_reg, blk_bits_next;
  logic [15:0] total_base;
  logic [BB_W-1:0] size_added;
  logic [16:0] total_sum;

  assign total_base = start ? 16'(PREFIX_W) : total_reg;
  assign size_added = aligned_bits - base_bits;
  assign total_sum  = {1'b0, total_base} + 17'(size_added);

  always_comb begin
    total_next    = total_reg;
    blk_bits_next = blk_bits_reg;
    if (finish) begin
      blk_bits_next = total_reg;
      total_next    = 16'(PREFIX_W);
    end else if (accept) begin
      total_next = total_sum[16] ? 16'hFFFF : total_sum[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_reg    <= 16'(PREFIX_W);
      blk_bits_reg <= '0;
    end else begin
      total_reg    <= total_next;
      blk_bits_reg <= blk_bits_next;
    end
  end

  assign blk_bits_o = blk_bits_reg;
`endif

endmodule

// File: tb/tb_aidc_lite_code_packer.sv
// Directed + randomized bench for aidc_lite_code_packer against a bit-queue model.
module tb_aidc_lite_code_packer;

  localparam int DS = 66;
  localparam int SW = 7;
  localparam int OW = 64;
  localparam int MW = 8;
  localparam int AW = 3;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic          sop_i = 1'b0;
  logic          eop_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [DS-1:0] data_i = '0;
  logic [SW-1:0] size_i = '0;
  logic          ready_o, valid_o, done_o, fail_o;
  logic [AW-1:0] addr_o;
  logic [OW-1:0] data_o;
`ifdef AIDC_LITE_PACKER_STATS_EN
  logic [15:0]   blk_bits_o;
`endif

  aidc_lite_code_packer dut (
    .clk     (clk),
    .rst     (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sop_i   (sop_i),
    .eop_i   (eop_i),
    .data_i  (data_i),
    .size_i  (size_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .addr_o  (addr_o),
    .data_o  (data_o),
    .done_o  (done_o),
    .fail_o  (fail_o)
`ifdef AIDC_LITE_PACKER_STATS_EN
    ,
    .blk_bits_o (blk_bits_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  logic [DS-1:0] bd[$];
  logic [SW-1:0] bs[$];
  logic [OW-1:0] exp_data[$];
  int            exp_addr[$];
  logic [OW-1:0] got_data[$];
  int            got_addr[$];
  bit            exp_fail;

  always @(posedge clk) begin
    if (valid_o && ready_i) begin
      got_data.push_back(data_o);
      got_addr.push_back(int'(addr_o));
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ready();
    case (ready_mode)
      0:       ready_i = 1'b1;
      1:       ready_i = ($urandom_range(0, 3) != 0);
      default: ready_i = 1'b0;
    endcase
  endtask

  function automatic logic [DS-1:0] rand_data();
    return {2'($urandom()), $urandom(), $urandom()};
  endfunction

  // Model: concatenate prefix and clamped code fields into one bit stream,
  // then cut it into OW-bit words (zero-padding the tail of a finished block).
  task automatic build_expected(input bit terminated);
    bit q[$];
    int n;
    logic [OW-1:0] w;
    logic [PW-1:0] pfx;
    pfx = '0;
    for (int i = PW - 1; i >= 0; i--) q.push_back(pfx[i]);
    foreach (bd[b]) begin
      int sz;
      sz = (int'(bs[b]) > DS) ? DS : int'(bs[b]);
      for (int k = 0; k < sz; k++) q.push_back(bd[b][DS-1-k]);
    end
    n = terminated ? (q.size() + OW - 1) / OW : q.size() / OW;
    for (int wi = 0; wi < n; wi++) begin
      for (int k = 0; k < OW; k++) begin
        int idx;
        idx = wi * OW + k;
        w[OW-1-k] = (idx < q.size()) ? q[idx] : 1'b0;
      end
      if (wi < MW) begin
        exp_data.push_back(w);
        exp_addr.push_back(wi);
      end
    end
    exp_fail = (n > MW);
  endtask

  task automatic send_range(input int from, input int to, input bit sop_first, input bit eop_last);
    for (int i = from; i <= to; i++) begin
      bit accepted;
      accepted = 1'b0;
      @(negedge clk);
      set_ready();
      valid_i = 1'b1;
      sop_i   = (i == from) && sop_first;
      eop_i   = (i == to) && eop_last;
      data_i  = bd[i];
      size_i  = bs[i];
      for (int c = 0; c < 300; c++) begin
        #1;
        if (ready_o) begin
          accepted = 1'b1;
          @(posedge clk);
          break;
        end
        @(negedge clk);
        set_ready();
      end
      if (!accepted) chk("beat_accept", accepted, 1'b1);
    end
    @(negedge clk);
    valid_i = 1'b0;
    sop_i   = 1'b0;
    eop_i   = 1'b0;
  endtask

  task automatic check_block(input string tag);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      set_ready();
      #1;
      if (done_o) break;
    end
    chk({tag, "_done"}, done_o, 1'b1);
    chk({tag, "_count"}, got_data.size(), exp_data.size());
    for (int i = 0; i < got_data.size() && i < exp_data.size(); i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
      chk($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
    end
    chk({tag, "_fail"}, fail_o, exp_fail);
    $display("block %s: %0d words, fail=%0b", tag, got_data.size(), fail_o);
    bd.delete(); bs.delete();
    exp_data.delete(); exp_addr.delete();
    got_data.delete(); got_addr.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_done", done_o, 1'b1);
    chk("rst_fail", fail_o, 1'b0);
    chk("rst_addr", addr_o, 0);
    chk("rst_data", data_o, 0);

    // Basic three-beat block
    ready_mode = 0;
    bd.push_back(rand_data()); bs.push_back(7'd6);
    bd.push_back(rand_data()); bs.push_back(7'd34);
    bd.push_back(rand_data()); bs.push_back(7'd34);
    build_expected(1'b1);
    send_range(0, 2, 1'b1, 1'b1);
    check_block("basic");

    // Backpressure: word 0 must hold while ready_i is low
    ready_mode = 2;
    bd.push_back(rand_data()); bs.push_back(7'd66);
    bd.push_back(rand_data()); bs.push_back(7'd66);
    bd.push_back(rand_data()); bs.push_back(7'd20);
    build_expected(1'b1);
    send_range(0, 0, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      set_ready();
      #1;
      chk("bp_valid", valid_o, 1'b1);
      chk("bp_data", data_o, exp_data[0]);
      chk("bp_addr", addr_o, 0);
      chk("bp_ready", ready_o, 1'b0);
    end
    ready_mode = 0;
    send_range(1, 2, 1'b0, 1'b1);
    check_block("backpressure");

    // Overflow: 596 bits -> 10 words, only 8 emitted
    ready_mode = 0;
    for (int i = 0; i < 9; i++) begin
      bd.push_back(rand_data()); bs.push_back(7'd66);
    end
    build_expected(1'b1);
    send_range(0, 8, 1'b1, 1'b1);
    check_block("overflow");
    chk("overflow_fail_level", fail_o, 1'b1);

    // Sop mid-block: only full words of the abandoned block may appear
    ready_mode = 1;
    bd.push_back(rand_data()); bs.push_back(7'd34);
    bd.push_back(rand_data()); bs.push_back(7'd34);
    build_expected(1'b0);
    send_range(0, 1, 1'b1, 1'b0);
    bd.delete(); bs.delete();
    bd.push_back(rand_data()); bs.push_back(7'd40);
    bd.push_back(rand_data()); bs.push_back(7'd3);
    bd.push_back(rand_data()); bs.push_back(7'd50);
    build_expected(1'b1);
    send_range(0, 2, 1'b1, 1'b1);
    check_block("midsop");

    // Randomized blocks, including zero-length and over-size beats
    ready_mode = 1;
    for (int blk = 0; blk < 10; blk++) begin
      int nb;
      nb = $urandom_range(1, 10);
      for (int i = 0; i < nb; i++) begin
        bd.push_back(rand_data());
        if ($urandom_range(0, 7) == 0) bs.push_back(7'($urandom_range(67, 127)));
        else if ($urandom_range(0, 7) == 0) bs.push_back(7'd0);
        else bs.push_back(7'($urandom_range(1, 66)));
      end
      build_expected(1'b1);
      send_range(0, nb - 1, 1'b1, 1'b1);
      check_block($sformatf("rand%0d", blk));
    end

    // Reset while a word is held in DRAIN
    ready_mode = 2;
    bd.push_back(rand_data()); bs.push_back(7'd66);
    send_range(0, 0, 1'b1, 1'b1);
    #1;
    chk("drain_valid", valid_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("drain_rst_valid", valid_o, 1'b0);
    chk("drain_rst_addr", addr_o, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bd.delete(); bs.delete();
    got_data.delete(); got_addr.delete();
    ready_mode = 1;
    bd.push_back(rand_data()); bs.push_back(7'd62);
    bd.push_back(rand_data()); bs.push_back(7'd30);
    build_expected(1'b1);
    send_range(0, 1, 1'b1, 1'b1);
    check_block("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
